seq_11011_framer: RTL and testbench
===================================

SEQ_11011_FRAMER -- requirements
Module: seq_11011_framer

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter SYNC_W, default 5, sync word width.
REQ-003 Parameter SYNC, default 5'b11011, sync word, sent MSB first.
REQ-004 Parameter GUARD, default 2, count of trailing zero bits per frame.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 load  input  1  request to send one frame; sampled every rising edge.
REQ-008 data_in  input  DATA_W  payload; captured on the edge that accepts load.
REQ-009 n  output  1  registered serial bit stream; drives the 11011 detector input directly.
REQ-010 busy  output  1  high while a frame is being sent.
REQ-011 done  output  1  one-cycle pulse during the last bit of a frame.

Function
REQ-012 States SHALL be IDLE, SYNC, DATA and GUARD.
REQ-013 In IDLE, n=0, busy=0 and done=0.
REQ-014 The edge that samples load=1 in IDLE SHALL be the accept edge; it latches data_in and moves to SYNC.
REQ-015 Any load in a non-IDLE state SHALL be ignored, with no effect on the frame in flight or on later frames.
REQ-016 Starting the cycle after accept, n SHALL carry SYNC bits MSB first for SYNC_W cycles, then data_in bits MSB first for DATA_W cycles, then 0 for GUARD cycles.
REQ-017 Frame length L = SYNC_W+DATA_W+GUARD SHALL be 15 cycles at the defaults.
REQ-018 busy SHALL be 1 for exactly the L frame cycles.
REQ-019 done SHALL be 1 only in frame cycle L, the last GUARD cycle.
REQ-020 After frame cycle L the FSM SHALL return to IDLE.
REQ-021 With load held at 1, frames SHALL repeat every L+1 cycles, separated by exactly one IDLE cycle with n=0.
REQ-022 A bit counter SHALL be sized ceil(log2(max(SYNC_W,DATA_W,GUARD)+1)), reload per state, and never wrap past its state's terminal count.
REQ-023 With GUARD=0, done SHALL coincide with the last DATA bit.
REQ-024 data_in changes after the accept edge SHALL NOT affect the frame in flight.

Reset
REQ-025 A rising edge with rst=1 SHALL force the IDLE state, n=0, busy=0, done=0, and clear the shift register and counter.
REQ-026 rst=1 SHALL take priority over load on the same edge; no frame is accepted on that edge.
REQ-027 rst asserted mid-frame SHALL abort the frame at the next edge, with no done pulse and no resumption.

Structure
REQ-028 A shared package seq_frame_pkg SHALL hold the state enum, the default SYNC constant and the width constants.
REQ-029 Serialisation SHALL live in one sub-module frame_piso (parallel-load, MSB-first shift register with load/shift enables).
REQ-030 The FSM and counter SHALL stay in seq_11011_framer.

Verification
REQ-031 Bench SHALL cover: rst=1 for 2 cycles, then load=1 with data_in=8'hA5 for one cycle -> n = 1,1,0,1,1,1,0,1,0,0,1,0,1,0,0 on cycles 1-15; busy high for 15 cycles; done only on cycle 15.
REQ-032 Bench SHALL cover: load=1 with data_in=8'hFF at frame cycle 6 -> the stream is unchanged and no second frame starts.
REQ-033 Bench SHALL cover: load held high with data_in=8'h00 -> frames start every 16 cycles, and the idle gap carries n=0, busy=0.
REQ-034 Bench SHALL cover: rst=1 at frame cycle 8 -> next cycle n=0, busy=0, no done; a fresh load of 8'h3C afterwards produces a complete, correct frame.
REQ-035 Bench SHALL cover: loopback into the existing mealy 11011 detector with data_in=8'h1B -> exactly 2 detector pulses, on frame bits 5 and 13.
REQ-036 Bench SHALL cover: load and rst both 1 on the same edge -> IDLE is held and n stays 0.

Source files
------------

// File: rtl/seq_frame_pkg.sv
// Shared types and default constants for the 11011 sync-word framer.
// Holds the frame state enum and the bit-counter sizing helper.
package seq_frame_pkg;

  localparam int                DEFAULT_DATA_W = 8;
  localparam int                DEFAULT_SYNC_W = 5;
  localparam logic [4:0]        DEFAULT_SYNC   = 5'b11011;
  localparam int                DEFAULT_GUARD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_GUARD
  } frame_state_e;

  // Counter must hold the longest per-state run minus one; sized from the largest field.
  function automatic int cnt_width(input int sync_w, input int data_w, input int guard);
    int m;
    m = sync_w;
    if (data_w > m) m = data_w;
    if (guard > m) m = guard;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_11011_framer_if.sv
// Load/payload request and serial frame output bundle of the framer.
interface seq_11011_framer_if
  import seq_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              n;
  logic              busy;
  logic              done;

  modport master (
    output load,
    output data_in,
    input  n,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  data_in,
    output n,
    output busy,
    output done
  );

endinterface

// File: rtl/frame_piso.sv
// Parallel-load, MSB-first shift register; zeros shift in from the LSB end.
module frame_piso #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // NOTE: the shift register is reset explicitly so an aborted frame cannot leave stale bits on msb.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_11011_framer.sv
// Frame generator: sends SYNC, then the captured payload, then GUARD zeros on a registered serial line.
// The FSM and per-state bit counter live here; serialisation is delegated to frame_piso.
module seq_11011_framer
  import seq_frame_pkg::*;
#(
  parameter int                DATA_W = DEFAULT_DATA_W,
  parameter int                SYNC_W = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEFAULT_SYNC,
  parameter int                GUARD  = DEFAULT_GUARD
) (
  input logic               clk,
  input logic               rst,
  seq_11011_framer_if.slave bus
);

  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GUARD);
  localparam int SR_W  = SYNC_W + DATA_W;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SYNC_LAST  = cnt_t'(SYNC_W - 1);
  localparam cnt_t DATA_LAST  = cnt_t'(DATA_W - 1);
  localparam cnt_t GUARD_LAST = cnt_t'((GUARD > 0) ? GUARD - 1 : 0);

  frame_state_e state;
  cnt_t         cnt;
  logic         busy_q;
  logic         done_q;
  logic         accept;
  logic         shift;
  logic         serial;

  // Loads arriving mid-frame are dropped because accept is only possible from IDLE.
  assign accept = (state == ST_IDLE) && bus.load;
  assign shift  = (state == ST_SYNC) || (state == ST_DATA);

  frame_piso #(
    .W (SR_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .din   ({SYNC, bus.data_in}),
    .msb   (serial)
  );

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.load) begin
            state  <= ST_SYNC;
            cnt    <= SYNC_LAST;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (cnt == '0) begin
            state  <= ST_DATA;
            cnt    <= DATA_LAST;
            done_q <= (GUARD == 0) && (DATA_W == 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            if (GUARD > 0) begin
              state  <= ST_GUARD;
              cnt    <= GUARD_LAST;
              done_q <= (GUARD == 1);
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b0;
            end
          end else begin
            cnt    <= cnt - 1'b1;
            // Without guard bits the pulse lands on the final payload bit.
            done_q <= (GUARD == 0) && (cnt == cnt_t'(1));
          end
        end
        ST_GUARD: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            done_q <= (cnt == cnt_t'(1));
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.n    = serial;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_11011_framer.sv
// Scoreboard bench for seq_11011_framer: a frame-position model predicts {n,busy,done} per cycle,
// a monitor compares, and an in-bench 11011 detector checks the loopback pulse positions.
module tb_seq_11011_framer;

  localparam int         DATA_W = 8;
  localparam int         SYNC_W = 5;
  localparam logic [4:0] SYNC_V = 5'b11011;
  localparam int         GUARD  = 2;
  localparam int         L      = SYNC_W + DATA_W + GUARD;

  logic clk;
  logic rst;

  seq_11011_framer_if #(.DATA_W(DATA_W)) bus ();

  seq_11011_framer #(
    .DATA_W (DATA_W),
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC_V),
    .GUARD  (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  int         id_q[$];
  int         cyc = 0;

  // Reference model: position within the frame (0 = idle) and the full frame image.
  int         pos = 0;
  logic [L-1:0] frame = '0;

  // Detector hits, recorded as frame-bit positions (1-based, counted over busy cycles).
  int det_hits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [DATA_W-1:0] d);
    logic en, eb, ed;
    rst         = r;
    bus.load    = ld;
    bus.data_in = d;
    if (r) begin
      pos = 0;
    end else if (pos == 0) begin
      if (ld) begin
        frame = L'({SYNC_V, d}) << GUARD;
        pos   = 1;
      end
    end else begin
      pos = (pos == L) ? 0 : pos + 1;
    end
    en = (pos != 0) ? frame[L-pos] : 1'b0;
    eb = (pos != 0);
    ed = (pos == L);
    exp_q.push_back({en, eb, ed});
    id_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, DATA_W'($urandom));
  endtask

  // Monitor: compare the DUT against the scoreboard and feed the loopback detector.
  initial begin
    logic [2:0] got, e;
    logic [4:0] win;
    int         id;
    int         fbit;
    win  = '0;
    fbit = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        id  = id_q.pop_front();
        got = {bus.n, bus.busy, bus.done};
        check($sformatf("cyc%0d {n,busy,done}", id), 32'(got), 32'(e));
        fbit = bus.busy ? fbit + 1 : 0;
        win  = {win[3:0], bus.n};
        if (win == 5'b11011) det_hits.push_back(fbit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = '0;

    // Reset for two cycles, then a single A5 frame with payload churn after accept.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    idle(17);

    // Load of FF during frame cycle 6 must be ignored.
    step(1'b0, 1'b1, 8'h5A);
    for (int i = 1; i <= 16; i++) begin
      if (i == 6) step(1'b0, 1'b1, 8'hFF);
      else        step(1'b0, 1'b0, DATA_W'($urandom));
    end
    idle(3);

    // Load held high: back-to-back frames every L+1 cycles.
    for (int i = 0; i < 3 * (L + 1); i++) step(1'b0, 1'b1, 8'h00);
    idle(3);

    // Reset at frame cycle 8 aborts the frame; then a fresh 3C frame.
    step(1'b0, 1'b1, 8'hC3);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) step(1'b1, 1'b0, 8'h00);
      else        step(1'b0, 1'b0, DATA_W'($urandom));
    end
    idle(3);
    step(1'b0, 1'b1, 8'h3C);
    idle(18);

    // rst and load on the same edge: nothing is accepted.
    step(1'b1, 1'b1, 8'hFF);
    idle(4);

    // Loopback into the 11011 detector with payload 1B.
    det_hits.delete();
    step(1'b0, 1'b1, 8'h1B);
    idle(17);
    @(negedge clk);
    #1;
    check("det pulse count", 32'(det_hits.size()), 32'd2);
    check("det pulse 1 bit", (det_hits.size() > 0) ? 32'(det_hits[0]) : 32'hFFFF_FFFF, 32'd5);
    check("det pulse 2 bit", (det_hits.size() > 1) ? 32'(det_hits[1]) : 32'hFFFF_FFFF, 32'd13);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), DATA_W'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
